// File: rtl/approx_adder_err_sweeper.sv
// approx_adder_err_sweeper: exhaustive error-evaluation sequencer for an external combinational approximate adder
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start, abort begin a sweep (IDLE only) / cancel a running sweep (RUN only)
//   vec_out      input vector driven to the approximate adder: A = low half, B = high half
//   approx_in    approximate adder result for the current vec_out
//   busy, done   sweep in progress / one-cycle completion pulse
//   pass         no vector exceeded ET (valid from done, held afterwards)
//   max_err, err_cnt, sum_err, fail_vec   accumulated error statistics
module approx_adder_err_sweeper #(
  parameter int IN_W       = 4,
  parameter int OUT_W      = 3,
  parameter int ET         = 7,
  parameter int EARLY_EXIT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [IN_W-1:0]       vec_out,
  input  logic [OUT_W-1:0]      approx_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W:0]         err_cnt,
  output logic [OUT_W+IN_W-1:0] sum_err,
  output logic [IN_W-1:0]       fail_vec
);
  localparam int H = IN_W / 2;
  if (OUT_W != H + 1 || IN_W % 2 != 0 || IN_W < 2) begin : g_bad_params
    $error("approx_adder_err_sweeper: IN_W must be even and >= 2, OUT_W must equal IN_W/2+1");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [OUT_W-1:0] exact, err;
  logic over, stop;
  assign exact = OUT_W'(vec_out[H-1:0]) + OUT_W'(vec_out[IN_W-1:H]);
  // absolute difference taken by ordering the operands, so it never wraps
  assign err   = approx_in >= exact ? approx_in - exact : exact - approx_in;
  assign over  = 32'(err) > ET;
  assign stop  = (EARLY_EXIT != 0 && over) || (&vec_out);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // abort wins over completion on the same edge
  always_comb
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (abort ? IDLE : stop ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec_out  <= '0;
      pass     <= 1'b0;
      max_err  <= '0;
      err_cnt  <= '0;
      sum_err  <= '0;
      fail_vec <= '0;
    end else if (state == IDLE && start) begin
      vec_out  <= '0;
      pass     <= 1'b1;
      max_err  <= '0;
      err_cnt  <= '0;
      sum_err  <= '0;
      fail_vec <= '0;
    end else if (state == RUN) begin
      // the vector on the abort edge is still counted; only pass is overridden
      sum_err <= sum_err + (OUT_W+IN_W)'(err);
      err_cnt <= err_cnt + (IN_W+1)'(|err);
      if (err > max_err) max_err <= err;
      if (over && pass) fail_vec <= vec_out;
      pass    <= pass && !over && !abort;
      vec_out <= abort ? '0 : stop ? vec_out : vec_out + IN_W'(1);
    end
endmodule

// File: tb/tb_approx_adder_err_sweeper.sv
// tb_approx_adder_err_sweeper: directed self-checking bench over four parameter configurations
module tb_approx_adder_err_sweeper;
  localparam int ETS[4] = '{7, 5, 5, 3};
  localparam int EES[4] = '{0, 0, 1, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic [3:0] st = '0, ab = '0;
  logic [3:0] busy, done, pass;
  logic [3:0] vec [4];
  logic [2:0] apx [4];
  logic [2:0] mx [4];
  logic [4:0] cnt [4];
  logic [6:0] sm [4];
  logic [3:0] fv [4];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    // instance 0: exact adder (mode=0) or tied to 0 (mode=1); 1,2: tied to 0; 3: tied to 7
    assign apx[g] = g == 0 ? (mode ? 3'd0 : 3'(vec[g][1:0]) + 3'(vec[g][3:2])) :
                    g == 3 ? 3'd7 : 3'd0;
    approx_adder_err_sweeper #(.IN_W(4), .OUT_W(3), .ET(ETS[g]), .EARLY_EXIT(EES[g])) dut (
      .clk(clk), .rst_n(rst_n), .start(st[g]), .abort(ab[g]), .vec_out(vec[g]),
      .approx_in(apx[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .max_err(mx[g]), .err_cnt(cnt[g]), .sum_err(sm[g]), .fail_vec(fv[g]));
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_done(inout int n);
    while (!done[0] && n < 40) begin
      tick;
      n++;
    end
  endtask
  initial begin
    int n, bc, dn;
    int dc [4];
    int dk [4];
    #3;
    chk("rst_vec", vec[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_pass", pass[0], 0);
    chk("rst_stats", {mx[0], cnt[0], sm[0], fv[0]}, 0);
    tick;
    tick;
    rst_n = 1'b1;
    // exact adder full sweep
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    chk("ex_busy0", busy[0], 1);
    chk("ex_pass0", pass[0], 1);
    n = 0;
    bc = 0;
    while (!done[0] && n < 40) begin
      if (busy[0]) bc++;
      tick;
      n++;
    end
    chk("ex_done_lat", n, 16);
    chk("ex_busy_cycles", bc, 16);
    chk("ex_busy_at_done", busy[0], 0);
    chk("ex_pass", pass[0], 1);
    chk("ex_max", mx[0], 0);
    chk("ex_cnt", cnt[0], 0);
    chk("ex_sum", sm[0], 0);
    chk("ex_fv", fv[0], 0);
    tick;
    chk("ex_done_pulse", done[0], 0);
    chk("ex_pass_hold", pass[0], 1);
    // tied-0 adder with a start pulse in the middle of the sweep
    mode = 1'b1;
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    tick;
    tick;
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    chk("sr_vec", vec[0], 3);
    n = 3;
    wait_done(n);
    chk("z0_done_lat", n, 16);
    chk("z0_pass", pass[0], 1);
    chk("z0_max", mx[0], 6);
    chk("z0_cnt", cnt[0], 15);
    chk("z0_sum", sm[0], 48);
    chk("z0_fv", fv[0], 0);
    dn = 0;
    repeat (20) begin
      tick;
      if (done[0]) dn++;
    end
    chk("sr_extra_done", dn, 0);
    // abort at vec_out=5
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    repeat (5) tick;
    chk("ab_vec5", vec[0], 5);
    ab[0] = 1'b1;
    tick;
    ab[0] = 1'b0;
    chk("ab_busy", busy[0], 0);
    chk("ab_vec", vec[0], 0);
    chk("ab_done", done[0], 0);
    chk("ab_pass", pass[0], 0);
    chk("ab_cnt", cnt[0], 5);
    chk("ab_sum", sm[0], 9);
    chk("ab_max", mx[0], 3);
    dn = 0;
    repeat (20) begin
      tick;
      if (done[0]) dn++;
    end
    chk("ab_no_done", dn, 0);
    // asynchronous reset at vec_out=9
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    repeat (9) tick;
    chk("rs_vec9", vec[0], 9);
    rst_n = 1'b0;
    #1;
    chk("rs_vec", vec[0], 0);
    chk("rs_busy", busy[0], 0);
    chk("rs_done", done[0], 0);
    chk("rs_pass", pass[0], 0);
    chk("rs_stats", {mx[0], cnt[0], sm[0], fv[0]}, 0);
    tick;
    rst_n = 1'b1;
    mode = 1'b0;
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    n = 0;
    wait_done(n);
    chk("rs_done_lat", n, 16);
    chk("rs_pass_after", pass[0], 1);
    chk("rs_stats_after", {mx[0], cnt[0], sm[0], fv[0]}, 0);
    // instances 1..3 swept together
    st[3:1] = 3'b111;
    tick;
    st[3:1] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      dc[i] = 0;
      dk[i] = 0;
    end
    for (int c = 1; c <= 20; c++) begin
      for (int i = 1; i < 4; i++)
        if (done[i]) begin
          dk[i]++;
          dc[i] = c;
        end
      tick;
    end
    chk("z5_done_cyc", dc[1], 17);
    chk("z5_done_num", dk[1], 1);
    chk("z5_pass", pass[1], 0);
    chk("z5_fv", fv[1], 15);
    chk("z5_max", mx[1], 6);
    chk("z5_cnt", cnt[1], 15);
    chk("z5_sum", sm[1], 48);
    chk("ee5_done_cyc", dc[2], 17);
    chk("ee5_done_num", dk[2], 1);
    chk("ee5_pass", pass[2], 0);
    chk("ee5_fv", fv[2], 15);
    chk("ee5_vec_hold", vec[2], 15);
    chk("ee5_sum", sm[2], 48);
    chk("ee3_done_cyc", dc[3], 2);
    chk("ee3_done_num", dk[3], 1);
    chk("ee3_pass", pass[3], 0);
    chk("ee3_fv", fv[3], 0);
    chk("ee3_vec_hold", vec[3], 0);
    chk("ee3_max", mx[3], 7);
    chk("ee3_cnt", cnt[3], 1);
    chk("ee3_sum", sm[3], 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
